// File: rtl/i2s_slave.sv
// I2S target-side transceiver: bus clocks come from an external master and are
// oversampled on the local system clock; RX words are deserialized, TX words serialized.
module i2s_slave #(
    parameter int DATA_BIT = 16
) (
    input  logic                i_clk_12_288,
    input  logic                i_reset_n,
    input  logic                i_sclk,
    input  logic                i_lrclk,
    input  logic                i_rx_sd,
    output logic                o_tx_sd,
    input  logic [DATA_BIT-1:0] i_audio_l,
    input  logic [DATA_BIT-1:0] i_audio_r,
    output logic                o_tx_load,
    output logic [DATA_BIT-1:0] o_audio_l,
    output logic [DATA_BIT-1:0] o_audio_r,
    output logic                o_audio_valid,
    output logic                o_locked,
    output logic                o_frame_err
);

    localparam int CNT_W = $clog2(DATA_BIT + 1);

    typedef enum logic [1:0] {
        StUnlocked = 2'd0,
        StLeft     = 2'd1,
        StRight    = 2'd2
    } state_e;

    state_e              r_state;
    logic                r_sclk_s1;
    logic                r_sclk_s2;
    logic                r_sclk_hist;
    logic                r_lrclk_s1;
    logic                r_lrclk_s2;
    logic                r_sd_s1;
    logic                r_sd_s2;
    logic                r_ws_last;
    logic [DATA_BIT-2:0] r_rx_shift;
    logic [DATA_BIT-1:0] r_left_stage;
    logic [DATA_BIT-1:0] r_tx_shift;
    logic [DATA_BIT-1:0] r_hold_r;
    logic [CNT_W-1:0]    r_bit_cnt;

    logic                w_rise;
    logic                w_ws;
    logic                w_trans;
    logic                w_count_ok;
    logic [DATA_BIT-1:0] w_rx_word;

    assign w_rise     = r_sclk_s2 & ~r_sclk_hist;
    assign w_ws       = r_lrclk_s2;
    assign w_trans    = w_ws ^ r_ws_last;
    // On a trans rise the sampled bit is the LSB of the slot that just ended.
    assign w_rx_word  = {r_rx_shift, r_sd_s2};
    assign w_count_ok = (r_bit_cnt == CNT_W'(DATA_BIT - 1));
    assign o_tx_sd    = r_tx_shift[DATA_BIT-1];

    always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StUnlocked;
            r_sclk_s1     <= 1'b0;
            r_sclk_s2     <= 1'b0;
            r_sclk_hist   <= 1'b0;
            r_lrclk_s1    <= 1'b0;
            r_lrclk_s2    <= 1'b0;
            r_sd_s1       <= 1'b0;
            r_sd_s2       <= 1'b0;
            r_ws_last     <= 1'b0;
            r_rx_shift    <= '0;
            r_left_stage  <= '0;
            r_tx_shift    <= '0;
            r_hold_r      <= '0;
            r_bit_cnt     <= '0;
            o_tx_load     <= 1'b0;
            o_audio_l     <= '0;
            o_audio_r     <= '0;
            o_audio_valid <= 1'b0;
            o_locked      <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            r_sclk_s1     <= i_sclk;
            r_sclk_s2     <= r_sclk_s1;
            r_sclk_hist   <= r_sclk_s2;
            r_lrclk_s1    <= i_lrclk;
            r_lrclk_s2    <= r_lrclk_s1;
            r_sd_s1       <= i_rx_sd;
            r_sd_s2       <= r_sd_s1;
            o_tx_load     <= 1'b0;
            o_audio_valid <= 1'b0;
            o_frame_err   <= 1'b0;

            if (w_rise) begin
                r_ws_last  <= w_ws;
                r_rx_shift <= w_rx_word[DATA_BIT-2:0];

                if (w_trans) begin
                    r_bit_cnt <= '0;

                    // TX reloads on every word-select flip, locked or not.
                    if (!w_ws) begin
                        r_hold_r   <= i_audio_r;
                        r_tx_shift <= i_audio_l;
                        o_tx_load  <= 1'b1;
                    end else begin
                        r_tx_shift <= r_hold_r;
                    end

                    if ((r_state != StUnlocked) && !w_count_ok) begin
                        o_frame_err <= 1'b1;
                        o_locked    <= 1'b0;
                        r_state     <= StUnlocked;
                    end else begin
                        case (r_state)
                            StUnlocked: begin
                                if (!w_ws) r_state <= StLeft;
                            end
                            StLeft: begin
                                if (w_ws) begin
                                    r_left_stage <= w_rx_word;
                                    r_state      <= StRight;
                                end
                            end
                            StRight: begin
                                if (!w_ws) begin
                                    o_audio_l     <= r_left_stage;
                                    o_audio_r     <= w_rx_word;
                                    o_audio_valid <= 1'b1;
                                    o_locked      <= 1'b1;
                                    r_state       <= StLeft;
                                end
                            end
                            default: r_state <= StUnlocked;
                        endcase
                    end
                end else begin
                    if (r_bit_cnt != CNT_W'(DATA_BIT)) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    r_tx_shift <= {r_tx_shift[DATA_BIT-2:0], 1'b0};
                end
            end
        end
    end

endmodule
